// File: rtl/bcd_scan_driver.sv
// Binary-to-BCD converter (sequential double-dabble) with time-multiplexed digit scan output.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.
module bcd_scan_driver #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned BIN_W      = 14,
   parameter int unsigned SCAN_DIV   = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [BIN_W-1:0]      in_value,
   output logic                  in_ready,
   output logic [3:0]            digit,
   output logic [NUM_DIGITS-1:0] digit_sel,
   output logic                  blank,
   output logic                  overflow
);

   localparam int unsigned DW = NUM_DIGITS * 4;
   // One spare nibble of headroom; anything above DW is dropped at commit.
   localparam int unsigned AW = DW + 4;
   localparam int unsigned CW = $clog2(BIN_W + 1);
   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [63:0] MaxVal = 64'(10 ** NUM_DIGITS) - 64'd1;

   typedef enum logic [0:0] {StIdle, StConvert} state_e;

   state_e          state_q, state_d;
   logic [BIN_W-1:0] shift_q, shift_d;
   logic [AW-1:0]   bcd_q, bcd_d, bcd_adj, bcd_shift;
   logic [CW-1:0]   iter_q, iter_d;
   logic            pend_q, pend_d;
   logic [DW-1:0]   disp_q, disp_d;
   logic            ovf_q, ovf_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [63:0]     in_ext;

   assign in_ext   = 64'(in_value);
   assign in_ready = (state_q == StIdle);
   assign overflow = ovf_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         shift_q <= '0;
         bcd_q   <= '0;
         iter_q  <= '0;
         pend_q  <= 1'b0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         presc_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
         iter_q  <= iter_d;
         pend_q  <= pend_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < NUM_DIGITS + 1; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      bcd_shift = {bcd_adj[AW-2:0], shift_q[BIN_W-1]};
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bcd_d   = bcd_q;
      iter_d  = iter_q;
      pend_d  = pend_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               state_d = StConvert;
               shift_d = in_value;
               bcd_d   = '0;
               iter_d  = '0;
               pend_d  = (in_ext > MaxVal);
            end
         end
         StConvert: begin
            bcd_d   = bcd_shift;
            shift_d = shift_q << 1;
            iter_d  = iter_q + CW'(1);
            if (iter_q == CW'(BIN_W - 1)) begin
               disp_d  = pend_q ? {NUM_DIGITS{4'h9}} : bcd_shift[DW-1:0];
               ovf_d   = pend_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Scan runs free of the converter; commits never disturb it.
   always_comb begin
      presc_d = presc_q + PW'(1);
      idx_d   = idx_q;
      if (presc_q == PW'(SCAN_DIV - 1)) begin
         presc_d = '0;
         idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
   end

   always_comb begin
      digit     = 4'd0;
      digit_sel = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            digit        = disp_q[4*i +: 4];
            digit_sel[i] = 1'b1;
         end
      end
   end

`ifdef BCD_SCAN_LZB_EN
   logic [IW-1:0] msnz;

   // Position 0 is never blanked, so msnz starts at 0.
   always_comb begin
      msnz = '0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (disp_q[4*i +: 4] != 4'd0) msnz = IW'(i);
      end
   end

   assign blank = (idx_q > msnz);
`else
   assign blank = 1'b0;
`endif

endmodule
